// File: rtl/script_sequencer.sv
// Script sequencer: fetches 16-bit instructions from a synchronous ROM and drives the
// chef action block, handling timed waits, feedback-bit waits and jumps.
module script_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned TIMEOUT  = 1_000_000,
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic [7:0]        feedback_sig,
    output logic              act_en,
    output logic [7:0]        act_i_num,
    output logic [1:0]        act_func,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StActMove, StActHold,
        StWaitCnt, StWaitBit, StDone, StError
    } state_t;

    localparam logic [ADDR_W-1:0] PcMax = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [11:0]         ticks_q, ticks_d;
    logic [2:0]          wbit_q, wbit_d;
    logic                wlvl_q, wlvl_d;
    logic [7:0]          i_num_q, i_num_d;
    logic [1:0]          func_q, func_d;
    logic                act_en_q, busy_q, done_q, error_q;
    logic                adv;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ticks_d = ticks_q;
        wbit_d  = wbit_q;
        wlvl_d  = wlvl_q;
        i_num_d = i_num_q;
        func_d  = func_q;
        adv     = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                case (rom_data[15:14])
                    2'b00: begin
                        i_num_d = rom_data[7:0];
                        func_d  = rom_data[9:8];
                        cnt_d   = '0;
                        state_d = StActMove;
                    end
                    2'b01: begin
                        if (rom_data[13]) begin
                            wbit_d  = rom_data[2:0];
                            wlvl_d  = rom_data[3];
                            state_d = StWaitBit;
                        end else if (rom_data[11:0] == 12'd0) begin
                            adv = 1'b1;
                        end else begin
                            ticks_d = rom_data[11:0];
                            cnt_d   = '0;
                            state_d = StWaitCnt;
                        end
                    end
                    2'b10: begin
                        if (!rom_data[13] || feedback_sig[rom_data[12:10]]) begin
                            pc_d    = rom_data[ADDR_W-1:0];
                            state_d = StFetch;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                    default: state_d = StDone;
                endcase
            end
            StActMove: begin
                if (feedback_sig[2]) begin
                    if (HOLD_CYC == 0) begin
                        adv = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = StActHold;
                    end
                end else if (TIMEOUT != 0 && cnt_q == TIMEOUT - 1) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StActHold: begin
                if (cnt_q == HOLD_CYC - 1) adv = 1'b1;
                else cnt_d = cnt_q + 32'd1;
            end
            StWaitCnt: begin
                if (cnt_q == TICK_DIV - 1) begin
                    cnt_d = '0;
                    if (ticks_q == 12'd1) adv = 1'b1;
                    else ticks_d = ticks_q - 12'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitBit: begin
                if (feedback_sig[wbit_q] == wlvl_q) adv = 1'b1;
            end
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase

        // pc never wraps: stepping past the last address is a script error
        if (adv) begin
            if (pc_q == PcMax) begin
                state_d = StError;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end
        end

        if (stop) begin
            state_d = StIdle;
            pc_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            cnt_q    <= '0;
            ticks_q  <= '0;
            wbit_q   <= '0;
            wlvl_q   <= 1'b0;
            i_num_q  <= '0;
            func_q   <= '0;
            act_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ticks_q  <= ticks_d;
            wbit_q   <= wbit_d;
            wlvl_q   <= wlvl_d;
            i_num_q  <= i_num_d;
            func_q   <= func_d;
            act_en_q <= (state_d == StActMove) || (state_d == StActHold);
            busy_q   <= !((state_d == StIdle) || (state_d == StDone) || (state_d == StError));
            done_q   <= (state_d == StDone);
            error_q  <= (state_d == StError);
        end
    end

    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign act_en    = act_en_q;
    assign act_i_num = i_num_q;
    assign act_func  = func_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
